// File: rtl/mdu_pkg.sv
// mdu_pkg: MDUOp encodings, default latencies and controller state type
// shared by the multiply/divide unit and the instruction decoder.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'b0000,
    MDU_MULT  = 4'b0001,
    MDU_MULTU = 4'b0010,
    MDU_DIV   = 4'b0011,
    MDU_DIVU  = 4'b0100,
    MDU_MTHI  = 4'b0101,
    MDU_MTLO  = 4'b0110,
    MDU_MFHI  = 4'b0111,
    MDU_MFLO  = 4'b1000
  } mdu_op_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the architectural HI/LO.
// Ports: clk, reset (sync, active-high), start, MDUOp[3:0], A, B -> busy, HI, LO, out.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  mdu_state_e  r_state, w_state_nx;
  logic [7:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_thi, r_tlo;
  logic        r_wr;

  logic        w_is_mul, w_is_div, w_accept, w_done;
  logic [63:0] w_smul, w_umul;
  logic [31:0] w_ua, w_ub, w_ubd, w_uq, w_ur;
  logic [31:0] w_bd, w_dq, w_dr;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_is_mul = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
  assign w_is_div = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);
  assign w_accept = (r_state == ST_IDLE) && start && (w_is_mul || w_is_div);
  assign w_done   = (r_state == ST_BUSY) && (r_cnt == 8'd1);

  // Sign-extended operands: the low 64 bits of the product are the signed product.
  assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_umul = {32'b0, A} * {32'b0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_ua  = A[31] ? -A : A;
  assign w_ub  = B[31] ? -B : B;
  assign w_ubd = (w_ub == 32'd0) ? 32'd1 : w_ub;
  assign w_uq  = w_ua / w_ubd;
  assign w_ur  = w_ua % w_ubd;

  // Divisor forced nonzero; a zero divisor suppresses the writeback anyway.
  assign w_bd = (B == 32'd0) ? 32'd1 : B;
  assign w_dq = A / w_bd;
  assign w_dr = A % w_bd;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    unique case (1'b1)
      (MDUOp == MDU_MULT): begin
        w_res_hi = w_smul[63:32];
        w_res_lo = w_smul[31:0];
      end
      (MDUOp == MDU_MULTU): begin
        w_res_hi = w_umul[63:32];
        w_res_lo = w_umul[31:0];
      end
      (MDUOp == MDU_DIV): begin
        w_res_lo = (A[31] ^ B[31]) ? -w_uq : w_uq;
        w_res_hi = A[31] ? -w_ur : w_ur;
      end
      (MDUOp == MDU_DIVU): begin
        w_res_lo = w_dq;
        w_res_hi = w_dr;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = ST_BUSY;
      ST_BUSY: if (w_done) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_thi   <= 32'd0;
      r_tlo   <= 32'd0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_thi <= w_res_hi;
        r_tlo <= w_res_lo;
        r_wr  <= !(w_is_div && (B == 32'd0));
        r_cnt <= w_is_mul ? 8'(MUL_LAT) : 8'(DIV_LAT);
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - 8'd1;
        if (w_done && r_wr) begin
          r_hi <= r_thi;
          r_lo <= r_tlo;
        end
      end else if (MDUOp == MDU_MTHI) begin
        r_hi <= A;
      end else if (MDUOp == MDU_MTLO) begin
        r_lo <= A;
      end
    end
  end

  assign busy = (r_state == ST_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;
  assign out  = (MDUOp == MDU_MFHI) ? r_hi :
                (MDUOp == MDU_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed stimulus against a behavioural HI/LO model,
// checking busy/HI/LO/out every cycle plus literal expectations.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, out;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  bit          p_wr = 1'b0;
  int          m_left = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic model(bit r, bit st, logic [3:0] op,
                       logic [31:0] a, logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned up;
    if (r) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (st && op >= 4'd1 && op <= 4'd4) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p_wr = 1'b1;
      case (op)
        4'd1: begin sp = sa * sb; {p_hi, p_lo} = sp; m_left = 5; end
        4'd2: begin up = 64'(a) * 64'(b); {p_hi, p_lo} = up; m_left = 5; end
        4'd3: begin
          m_left = 10;
          if (b == 0) p_wr = 1'b0;
          else begin
            sp = sa / sb; p_lo = sp[31:0];
            sp = sa % sb; p_hi = sp[31:0];
          end
        end
        default: begin
          m_left = 10;
          if (b == 0) p_wr = 1'b0;
          else begin p_lo = a / b; p_hi = a % b; end
        end
      endcase
    end else if (op == 4'd5) m_hi = a;
    else if (op == 4'd6) m_lo = a;
  endtask

  task automatic cyc(bit r, bit st, logic [3:0] op,
                     logic [31:0] a, logic [31:0] b, string tag);
    reset = r; start = st; MDUOp = op; A = a; B = b;
    #1;
    chk({tag, " out"}, out, (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0);
    model(r, st, op, a, b);
    @(posedge clk);
    #1;
    chk({tag, " busy"}, 32'(busy), 32'(m_left > 0));
    chk({tag, " HI"}, HI, m_hi);
    chk({tag, " LO"}, LO, m_lo);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDUOp = 4'd0; A = 0; B = 0;
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, "rst");
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, "rst");
    chk("rst HI lit", HI, 32'h0);
    chk("rst busy lit", 32'(busy), 32'd0);

    cyc(1'b0, 1'b1, 4'd1, 32'hFFFFFFFE, 32'd3, "mult");
    idle(5, "mult");
    chk("mult HI lit", HI, 32'hFFFFFFFF);
    chk("mult LO lit", LO, 32'hFFFFFFFA);

    cyc(1'b0, 1'b1, 4'd2, 32'hFFFFFFFE, 32'd3, "multu");
    idle(5, "multu");
    chk("multu HI lit", HI, 32'h00000002);
    chk("multu LO lit", LO, 32'hFFFFFFFA);

    cyc(1'b0, 1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, "div");
    idle(10, "div");
    chk("div LO lit", LO, 32'hFFFFFFFD);
    chk("div HI lit", HI, 32'hFFFFFFFF);

    // Start on the completion-plus-one cycle is accepted straight away.
    cyc(1'b0, 1'b1, 4'd4, 32'hFFFFFFF9, 32'd2, "divu");
    idle(10, "divu");
    chk("divu LO lit", LO, 32'h7FFFFFFC);
    chk("divu HI lit", HI, 32'h00000001);

    cyc(1'b0, 1'b0, 4'd5, 32'h00001234, 32'd0, "mthi");
    cyc(1'b0, 1'b0, 4'd6, 32'h00005678, 32'd0, "mtlo");
    cyc(1'b0, 1'b1, 4'd3, 32'h00000055, 32'd0, "div0");
    idle(10, "div0");
    chk("div0 HI lit", HI, 32'h00001234);
    chk("div0 LO lit", LO, 32'h00005678);
    reset = 1'b0; start = 1'b0; MDUOp = 4'd7; #1;
    chk("mfhi out lit", out, 32'h00001234);
    cyc(1'b0, 1'b0, 4'd7, 32'd0, 32'd0, "mfhi");
    cyc(1'b0, 1'b0, 4'd8, 32'd0, 32'd0, "mflo");

    cyc(1'b0, 1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, "ovf");
    idle(10, "ovf");
    chk("ovf LO lit", LO, 32'h80000000);
    chk("ovf HI lit", HI, 32'h00000000);

    cyc(1'b0, 1'b1, 4'd1, 32'd2, 32'd3, "sbusy");
    idle(1, "sbusy");
    cyc(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, "sbusy ign");
    cyc(1'b0, 1'b0, 4'd6, 32'hDEADBEEF, 32'd0, "sbusy mtlo");
    idle(2, "sbusy");
    chk("sbusy HI lit", HI, 32'd0);
    chk("sbusy LO lit", LO, 32'd6);
    chk("sbusy done lit", 32'(busy), 32'd0);

    cyc(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, "rmid");
    idle(2, "rmid");
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, "rmid rst");
    chk("rmid busy lit", 32'(busy), 32'd0);
    chk("rmid LO lit", LO, 32'd0);
    idle(12, "rmid after");
    chk("rmid late LO lit", LO, 32'd0);

    cyc(1'b0, 1'b1, 4'd2, 32'h12345678, 32'h9ABCDEF0, "multu2");
    idle(5, "multu2");
    cyc(1'b0, 1'b1, 4'd3, 32'h80000001, 32'h00000010, "div2");
    idle(10, "div2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle arithmetic unit in the execute stage and serves MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Unlike the combinational arithmetic path, results arrive after a fixed multi-cycle latency.
- Exposes a busy flag; the external stall logic uses busy to hold dependent instructions.

Parameters:
- MUL_LAT, 5, number of busy cycles for MULT/MULTU.
- DIV_LAT, 10, number of busy cycles for DIV/DIVU.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a mult/div when MDUOp selects one.
- MDUOp  input  4  operation select: 0000 NONE, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MFHI, 1000 MFLO; other codes behave as NONE.
- A  input  32  rs operand; dividend, multiplicand, or MTHI/MTLO source.
- B  input  32  rt operand; divisor or multiplier.
- busy  output  1  registered; high while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- out  output  32  combinational read: HI when MDUOp=MFHI, LO when MDUOp=MFLO, else 0.

Behaviour:
- Reset: on a clk edge with reset=1, HI=0, LO=0, busy=0, counter=0, and any in-flight result is discarded. Reset overrides every other input in the same cycle. This includes reset mid-operation: no late writeback ever occurs.
- Accept: in cycle T with busy=0, start=1 and MDUOp in {MULT, MULTU, DIV, DIVU}, the edge ending T does the following:
  - computes the result from A and B into internal temp_hi/temp_lo registers;
  - loads counter with MUL_LAT or DIV_LAT;
  - sets busy=1.
- Busy window:
  - busy=1 during cycles T+1 .. T+LAT; the counter decrements once per cycle.
  - On the edge ending cycle T+LAT, HI/LO take temp_hi/temp_lo and busy clears.
  - busy=0 and the new HI/LO are visible in cycle T+LAT+1.
- start while busy=1: ignored; operands are not re-latched and the counter is not restarted.
- start with any other MDUOp: ignored.
- MTHI/MTLO: when busy=0 and MDUOp=MTHI (MTLO), HI (LO) takes A at the edge, visible the next cycle. No start is needed. Ignored while busy=1.
- MFHI/MFLO: out reflects the current register value combinationally, with no side effects. While busy, out returns the old HI/LO; it is the stall logic's duty to block the read.
- Arithmetic:
  - MULT: 64-bit signed product of A and B; HI gets bits [63:32], LO gets bits [31:0].
  - MULTU: 64-bit unsigned product, same HI/LO split.
  - DIV: signed. LO is the quotient, truncated toward zero. HI is the remainder, carrying the sign of the dividend.
  - DIVU: unsigned. LO is the quotient, HI is the remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (B=0): still busy for DIV_LAT cycles; HI and LO are left unchanged at completion.
- Completion cycle: busy=0 in T+LAT+1, so a new start in that cycle is accepted.
- External stall condition: (start & mult/div op) | busy. This is documented here; it is implemented outside the block.

Decomposition:
- Shared package/header mdu_defs holds the MDUOp encodings (NONE..MFLO) and the default MUL_LAT/DIV_LAT constants. The decoder/controller includes the same file.
- Single module. The counter plus temp registers are too small to justify a sub-module.

Test Plan:
1. MULT, A=0xFFFFFFFE, B=0x00000003, start=1 -> busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU with the same operands -> after 5 busy cycles, HI=0x00000002, LO=0xFFFFFFFA.
3. Signed and unsigned divide on the same dividend:
   - DIV, A=0xFFFFFFF9, B=0x00000002 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
4. Divide by zero:
   - Set up with MTHI A=0x00001234, then MTLO A=0x00005678.
   - DIV, B=0 -> busy for 10 cycles; afterwards HI=0x00001234, LO=0x00005678.
   - MFHI reads out=0x00001234.
5. Start while busy:
   - Issue MULT 2*3.
   - On busy cycle 2, assert start with DIV 100/7 -> ignored.
   - busy stays for the original 5 cycles; result HI=0, LO=6.
   - MTLO asserted while busy leaves LO unchanged.
6. Reset mid-operation:
   - Issue DIV 100/7 and assert reset on busy cycle 3.
   - Next cycle: busy=0, HI=0, LO=0.
   - No write occurs at the original completion cycle.
